// File: rtl/csa_accumulator.sv
// Carry-save accumulator: folds a packet of 64-bit operands into sum/carry rows for a downstream KPG/prefix adder.
// Optional macro CSA_TERM_COUNT_EN adds a saturating out_terms beat counter.
module csa_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_a,
    output logic [63:0]      out_b,
    output logic [7:0]       out_xin,
`ifdef CSA_TERM_COUNT_EN
    output logic [CNT_W-1:0] out_terms,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0] KPG_KILL = 8'h6B;

    state_t      r_state;
    logic [63:0] r_sumRow;
    logic [63:0] r_carryRow;
    logic        r_outValid;
    logic        r_inReady;
    logic        r_busy;

    logic        w_accept;
    logic        w_release;
    logic [63:0] w_nextSum;
    logic [63:0] w_nextCarry;

    generate
        if (CNT_W < 1) begin : g_badCntW
            $error("CNT_W must be at least 1");
        end
    endgenerate

    assign w_accept    = in_valid && r_inReady;
    assign w_release   = r_outValid && out_ready;
    assign w_nextSum   = r_sumRow ^ r_carryRow ^ in_data;
    // Majority shifted left; bit 63's carry falls off, keeping the sum modulo 2^64.
    assign w_nextCarry = ((r_sumRow & r_carryRow) | (r_sumRow & in_data) | (r_carryRow & in_data)) << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sumRow   <= '0;
            r_carryRow <= '0;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ACC: begin
                    if (w_accept) begin
                        r_sumRow   <= w_nextSum;
                        r_carryRow <= w_nextCarry;
                        r_busy     <= 1'b1;
                        if (in_last) begin
                            r_state    <= HOLD;
                            r_outValid <= 1'b1;
                            r_inReady  <= 1'b0;
                        end else begin
                            r_state <= ACC;
                        end
                    end
                end
                HOLD: begin
                    if (w_release) begin
                        r_state    <= IDLE;
                        r_sumRow   <= '0;
                        r_carryRow <= '0;
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_sumRow   <= '0;
                    r_carryRow <= '0;
                    r_outValid <= 1'b0;
                    r_inReady  <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

`ifdef CSA_TERM_COUNT_EN
    logic [CNT_W-1:0] r_terms;

    // The first beat of a packet restarts the count even if a stale value remains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_terms <= '0;
        end else if (w_accept) begin
            if (r_state == IDLE) begin
                r_terms <= CNT_W'(1);
            end else if (r_terms != {CNT_W{1'b1}}) begin
                r_terms <= r_terms + CNT_W'(1);
            end
        end else if (w_release) begin
            r_terms <= '0;
        end
    end

    assign out_terms = r_terms;
`endif

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign out_a     = r_sumRow;
    assign out_b     = r_carryRow;
    assign busy      = r_busy;
    assign out_xin   = KPG_KILL;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed self-checking bench for csa_accumulator; define CSA_TERM_COUNT_EN to also exercise out_terms.
module tb_csa_accumulator;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_a;
    logic [63:0]      out_b;
    logic [7:0]       out_xin;
    logic             busy;
`ifdef CSA_TERM_COUNT_EN
    logic [CNT_W-1:0] out_terms;
`endif

    int testsRun;
    int testsFailed;

    csa_accumulator #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_xin   (out_xin),
`ifdef CSA_TERM_COUNT_EN
        .out_terms (out_terms),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of input and returns 1 time unit after the rising edge.
    task automatic applyStimulus(input logic valid, input logic [63:0] data, input logic last);
        in_valid = valid;
        in_data  = data;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_last     = 1'b0;
        out_ready   = 1'b0;

        #3;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_a", out_a, 64'd0);
        checkOutput("rst_out_b", out_b, 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_xin", 64'(out_xin), 64'h6B);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rel_in_ready", 64'(in_ready), 64'd1);

        // Single beat packet.
        applyStimulus(1'b1, 64'h5, 1'b1);
        checkOutput("t1_out_valid", 64'(out_valid), 64'd1);
        checkOutput("t1_out_a", out_a, 64'h5);
        checkOutput("t1_out_b", out_b, 64'h0);
        checkOutput("t1_xin", 64'(out_xin), 64'h6B);
        checkOutput("t1_busy", 64'(busy), 64'd1);
        checkOutput("t1_in_ready", 64'(in_ready), 64'd0);
        handshake();
        checkOutput("t1_post_valid", 64'(out_valid), 64'd0);
        checkOutput("t1_post_busy", 64'(busy), 64'd0);
        checkOutput("t1_post_a", out_a, 64'h0);
        checkOutput("t1_post_ready", 64'(in_ready), 64'd1);

        // Three ones, with an idle gap inside the packet.
        applyStimulus(1'b1, 64'h1, 1'b0);
        checkOutput("t2_b1_busy", 64'(busy), 64'd1);
        checkOutput("t2_b1_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 64'h1, 1'b0);
        checkOutput("t2_b2_sum", dut.r_sumRow, 64'h0);
        checkOutput("t2_b2_carry", dut.r_carryRow, 64'h2);
        applyStimulus(1'b0, 64'hDEAD, 1'b1);
        checkOutput("t2_gap_sum", dut.r_sumRow, 64'h0);
        checkOutput("t2_gap_carry", dut.r_carryRow, 64'h2);
        checkOutput("t2_gap_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 64'h1, 1'b1);
        checkOutput("t2_out_valid", 64'(out_valid), 64'd1);
        checkOutput("t2_out_a", out_a, 64'h3);
        checkOutput("t2_out_b", out_b, 64'h0);
        handshake();

        // Wrap-around past 2^64.
        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        applyStimulus(1'b1, 64'h1, 1'b1);
        checkOutput("t3_out_a", out_a, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("t3_out_b", out_b, 64'h2);
        checkOutput("t3_sum", out_a + out_b, 64'h0);
        handshake();

        // Backpressure: junk beats offered in HOLD must be ignored.
        applyStimulus(1'b1, 64'h6, 1'b0);
        applyStimulus(1'b1, 64'hA, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 64'h1234_5678 + 64'(i), 1'(i % 2));
            checkOutput("t4_hold_valid", 64'(out_valid), 64'd1);
            checkOutput("t4_hold_a", out_a, 64'hC);
            checkOutput("t4_hold_b", out_b, 64'h4);
            checkOutput("t4_hold_ready", 64'(in_ready), 64'd0);
        end
        handshake();
        checkOutput("t4_rel_valid", 64'(out_valid), 64'd0);
        checkOutput("t4_rel_busy", 64'(busy), 64'd0);
        checkOutput("t4_rel_ready", 64'(in_ready), 64'd1);
        applyStimulus(1'b1, 64'h1, 1'b1);
        checkOutput("t4_next_a", out_a, 64'h1);
        checkOutput("t4_next_b", out_b, 64'h0);
        handshake();

        // Reset in the middle of a packet.
        applyStimulus(1'b1, 64'h3, 1'b0);
        applyStimulus(1'b1, 64'h4, 1'b0);
        checkOutput("t5_pre_sum", dut.r_sumRow, 64'h7);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_a", out_a, 64'h0);
        checkOutput("t5_rst_b", out_b, 64'h0);
        checkOutput("t5_rst_busy", 64'(busy), 64'd0);
        checkOutput("t5_rst_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 64'h7, 1'b1);
        checkOutput("t5_out_a", out_a, 64'h7);
        checkOutput("t5_out_b", out_b, 64'h0);
        checkOutput("t5_out_valid", 64'(out_valid), 64'd1);
        handshake();

`ifdef CSA_TERM_COUNT_EN
        // Term counter saturation, then a fresh short packet.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 64'h1, 1'(i == 299));
        end
        checkOutput("t6_terms_sat", 64'(out_terms), 64'd255);
        checkOutput("t6_sum", out_a + out_b, 64'd300);
        handshake();
        checkOutput("t6_terms_clr", 64'(out_terms), 64'd0);
        applyStimulus(1'b1, 64'h9, 1'b0);
        applyStimulus(1'b1, 64'h2, 1'b1);
        checkOutput("t6_terms_two", 64'(out_terms), 64'd2);
        checkOutput("t6_sum_two", out_a + out_b, 64'hB);
        handshake();
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/csa_accumulator.md
CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

Interface
REQ-001 SHALL provide parameter CNT_W, default 8: width of the optional term counter.
REQ-002 SHALL provide port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL provide port in_valid, input, 1: operand beat present.
REQ-005 SHALL provide port in_ready, output, 1: block can accept a beat.
REQ-006 SHALL provide port in_data, input, 64: operand (partial-product row).
REQ-007 SHALL provide port in_last, input, 1: final beat of the packet.
REQ-008 SHALL provide port out_valid, output, 1: result rows valid.
REQ-009 SHALL provide port out_ready, input, 1: downstream 64-bit KPG/prefix adder takes the rows.
REQ-010 SHALL provide port out_a, output, 64: sum row, feeding adder operand a.
REQ-011 SHALL provide port out_b, output, 64: carry row, feeding adder operand b.
REQ-012 SHALL provide port out_xin, output, 8: adder carry-in KPG code, constant 8'h6B ("k").
REQ-013 SHALL provide port busy, output, 1: high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, ACC and HOLD.
REQ-015 SHALL accept a beat when in_valid && in_ready is true.
REQ-016 SHALL drive in_ready high in IDLE and ACC, and low in HOLD.
REQ-017 SHALL update on each accepted beat: S' = S^C^d; C' = (maj(S,C,d) << 1), truncated to 64 bits (mod 2^64, carry out of bit 63 discarded).
REQ-018 SHALL hold S and C at zero in IDLE, so the first beat of a packet gives S=d, C=0.
REQ-019 SHALL make these transitions: IDLE→ACC on an accepted beat with in_last=0; IDLE or ACC→HOLD on an accepted beat with in_last=1; ACC→ACC otherwise.
REQ-020 SHALL assert out_valid in the cycle after the last beat is accepted (1-cycle latency), with out_a=S and out_b=C.
REQ-021 SHALL keep out_valid, out_a and out_b stable while in HOLD and out_ready is low.
REQ-022 SHALL, on out_valid && out_ready, clear S and C, deassert out_valid next cycle, and go to IDLE; a new beat is accepted no earlier than that next cycle.
REQ-023 SHALL ignore in_valid, in_data and in_last while in HOLD.
REQ-024 SHALL keep idle cycles within a packet (in_valid low in ACC) from changing state or S/C.
REQ-025 SHALL guarantee that out_a + out_b (mod 2^64) equals the sum of the packet's beats (mod 2^64).
REQ-026 SHALL drive out_xin = 8'h6B at all times, including during reset.

Reset
REQ-027 SHALL, on rst_n low, immediately and asynchronously set: state=IDLE, S=0, C=0, out_valid=0, out_a=0, out_b=0, busy=0, and in_ready=1 once reset is released.
REQ-028 SHALL discard any partial packet or pending result on a mid-packet or HOLD reset; the first beat after release starts a new packet.

Configuration
REQ-029 SHALL, with macro CSA_TERM_COUNT_EN defined, add output out_terms[CNT_W-1:0]:
- counts beats accepted in the current packet, including the last;
- saturates at 2^CNT_W-1;
- valid with out_valid, held stable in HOLD;
- cleared on output handshake and on reset.
REQ-030 SHALL, without CSA_TERM_COUNT_EN, have no out_terms port and no counter logic; all other behaviour is identical.

Verification
REQ-031 SHALL cover: single beat d=64'h5, last=1 → next cycle out_valid=1, out_a=64'h5, out_b=0, out_xin=8'h6B.
REQ-032 SHALL cover: beats 1, 1, 1 (last on third) → out_a=64'h3, out_b=0; intermediate S=0, C=2 after beat 2.
REQ-033 SHALL cover wrap-around: beats 64'hFFFF_FFFF_FFFF_FFFF, then 1 (last) → out_a=64'hFFFF_FFFF_FFFF_FFFE, out_b=64'h2; sum mod 2^64 = 0.
REQ-034 SHALL cover backpressure: out_ready low 5 cycles after result, in_valid high with junk → out_a/out_b unchanged, in_ready=0, no beat accepted; release gives a handshake and IDLE the next cycle.
REQ-035 SHALL cover reset mid-packet: after 2 beats (3, 4) assert rst_n low → outputs 0 at once; after release, single beat 64'h7 → out_a=64'h7, out_b=0.
REQ-036 SHALL cover, with CSA_TERM_COUNT_EN and CNT_W=8: 300 beats of 1 → out_terms=255 and out_a+out_b=300; then 2 beats → out_terms=2.
